// File: rtl/poll_scheduler_if.sv
// Signal bundle between poll_scheduler and its requesting clients.
// master = client side (enable/req/done), slave = scheduler side (grants and status).
`timescale 1ns/1ps

interface poll_scheduler_if #(
  parameter int N_REQ = 4,
  parameter int CNT_W = 23
) ();
  localparam int ID_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  // Handshake: a client raises req[i] and keeps it high while it wants service; once gnt[i]
  // is seen high the client owns the slot until it pulses done[i] or drops req[i]; the scheduler
  // then clears gnt[i] on the next rising edge. done is ignored for clients that are not granted.
  logic             enable;
  logic [N_REQ-1:0] req;
  logic [N_REQ-1:0] done;
  logic [N_REQ-1:0] gnt;
  logic             busy;
  logic             period_tick;
  logic             overrun;
  logic             timeout_flag;
  logic [ID_W-1:0]  last_id;
  logic [1:0]       dbg_state;
  logic [CNT_W-1:0] dbg_cnt;

  modport master (
    output enable, req, done,
    input  gnt, busy, period_tick, overrun, timeout_flag, last_id, dbg_state, dbg_cnt
  );

  modport slave (
    input  enable, req, done,
    output gnt, busy, period_tick, overrun, timeout_flag, last_id, dbg_state, dbg_cnt
  );
endinterface

// File: rtl/poll_scheduler.sv
// Periodic round-robin scheduler: each period opens a round granting every requester at most once.
// Optional grant watchdog enabled by defining SCHED_TIMEOUT_EN.
`timescale 1ns/1ps

module poll_scheduler #(
  parameter int N_REQ        = 4,
  parameter int PERIOD_CYC   = 5000000,
  parameter int SLOT_MAX_CYC = 100000,
  parameter int CNT_W        = 23
) (
  input  logic            clk1M,
  input  logic            rst_n,
  poll_scheduler_if.slave bus
);
  localparam int ID_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [CNT_W-1:0] PERIOD_LAST = CNT_W'(PERIOD_CYC - 1);

  if (N_REQ < 2 || N_REQ > 8 || PERIOD_CYC < 2 || (PERIOD_CYC - 1) >= (1 << CNT_W) ||
      SLOT_MAX_CYC < 1 || SLOT_MAX_CYC >= (1 << CNT_W)) begin : g_bad_cfg
    $error("poll_scheduler: parameters out of range for CNT_W");
  end

  typedef enum logic [1:0] {IDLE = 2'd0, SCAN = 2'd1, GRANT = 2'd2} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic             tick;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic [N_REQ-1:0] served_q, served_d;
  logic [ID_W-1:0]  ptr_q, ptr_d;
  logic [ID_W-1:0]  last_id_q, last_id_d;
  logic [ID_W-1:0]  ptr_next;
  logic             found;
  logic [ID_W-1:0]  pick;
  logic             release_c;
  logic             tout_q, tout_d;
`ifdef SCHED_TIMEOUT_EN
  localparam logic [CNT_W-1:0] SLOT_LAST = CNT_W'(SLOT_MAX_CYC - 1);
  logic [CNT_W-1:0] slot_q, slot_d;
`endif

  function automatic int wrap_idx(input int base, input int off);
    int s;
    s = base + off;
    if (s >= N_REQ) s = s - N_REQ;
    return s;
  endfunction

  assign tick = bus.enable && (cnt_q == PERIOD_LAST);

  always_ff @(posedge clk1M or negedge rst_n) begin
    if (!rst_n)                    cnt_q <= '0;
    else if (!bus.enable || tick)  cnt_q <= '0;
    else                           cnt_q <= cnt_q + CNT_W'(1);
  end

  // Rotating search: first unserved requester at or above ptr, wrapping around.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (!found && bus.req[wrap_idx(int'(ptr_q), k)] && !served_q[wrap_idx(int'(ptr_q), k)]) begin
        found = 1'b1;
        pick  = ID_W'(wrap_idx(int'(ptr_q), k));
      end
    end
  end

  assign release_c = bus.done[last_id_q] | ~bus.req[last_id_q];
  assign ptr_next  = (last_id_q == ID_W'(N_REQ - 1)) ? '0 : last_id_q + ID_W'(1);

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    served_d  = served_q;
    ptr_d     = ptr_q;
    last_id_d = last_id_q;
    tout_d    = 1'b0;
`ifdef SCHED_TIMEOUT_EN
    slot_d    = slot_q;
`endif
    if (!bus.enable) begin
      state_d  = IDLE;
      gnt_d    = '0;
      served_d = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          // A period with nobody asking is skipped so busy stays low.
          if (tick && (|bus.req)) begin
            state_d  = SCAN;
            served_d = '0;
          end
        end
        SCAN: begin
          if (found) begin
            gnt_d        = '0;
            gnt_d[pick]  = 1'b1;
            last_id_d    = pick;
            state_d      = GRANT;
`ifdef SCHED_TIMEOUT_EN
            slot_d       = '0;
`endif
          end else begin
            state_d  = IDLE;
            served_d = '0;
          end
        end
        GRANT: begin
          if (release_c) begin
            gnt_d               = '0;
            served_d[last_id_q] = 1'b1;
            ptr_d               = ptr_next;
            state_d             = SCAN;
          end
`ifdef SCHED_TIMEOUT_EN
          else if (slot_q == SLOT_LAST) begin
            gnt_d               = '0;
            served_d[last_id_q] = 1'b1;
            ptr_d               = ptr_next;
            state_d             = SCAN;
            tout_d              = 1'b1;
          end else begin
            slot_d = slot_q + CNT_W'(1);
          end
`endif
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk1M or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      gnt_q     <= '0;
      served_q  <= '0;
      ptr_q     <= '0;
      last_id_q <= '0;
      tout_q    <= 1'b0;
`ifdef SCHED_TIMEOUT_EN
      slot_q    <= '0;
`endif
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      served_q  <= served_d;
      ptr_q     <= ptr_d;
      last_id_q <= last_id_d;
      tout_q    <= tout_d;
`ifdef SCHED_TIMEOUT_EN
      slot_q    <= slot_d;
`endif
    end
  end

  assign bus.gnt         = gnt_q;
  assign bus.busy        = (state_q != IDLE);
  assign bus.period_tick = tick;
  assign bus.overrun     = tick && (state_q != IDLE);
  assign bus.last_id     = last_id_q;
  assign bus.dbg_state   = state_q;
  assign bus.dbg_cnt     = cnt_q;
`ifdef SCHED_TIMEOUT_EN
  assign bus.timeout_flag = tout_q;
`else
  assign bus.timeout_flag = 1'b0;
`endif

endmodule

// File: tb/tb_poll_scheduler.sv
// Directed bench for poll_scheduler (N_REQ=4, PERIOD_CYC=20, SLOT_MAX_CYC=5).
// Grant order is scoreboarded; timing, overrun, enable and reset behaviour are checked inline.
`timescale 1ns/1ps

module tb_poll_scheduler;
  localparam int N = 4;

  logic clk1M = 1'b0;
  logic rst_n;
  always #500 clk1M = ~clk1M;

  poll_scheduler_if #(.N_REQ(N), .CNT_W(23)) bus ();

  poll_scheduler #(.N_REQ(N), .PERIOD_CYC(20), .SLOT_MAX_CYC(5), .CNT_W(23)) dut (
    .clk1M (clk1M),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int cyc0    = 0;

  logic [N-1:0] exp_q[$];
  logic [N-1:0] gnt_prev;
  logic [N-1:0] exp_gnt;
  int           gnt_start = 0;
  int           last_len  = 0;

  always @(posedge clk1M) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int idx();
    return cyc - cyc0;
  endfunction

  task automatic step();
    @(negedge clk1M);
  endtask

  task automatic wait_gnt(input int budget, output int at);
    at = -1;
    for (int i = 0; i < budget; i++) begin
      step();
      if (bus.gnt != '0) begin
        at = idx();
        break;
      end
    end
  endtask

  // done raised in the third grant cycle, so each grant lasts three cycles
  task automatic serve();
    step();
    step();
    bus.done = bus.gnt;
    step();
    bus.done = '0;
  endtask

  // Scoreboard: every new grant must match the next expected client.
  always @(negedge clk1M) begin
    if (!rst_n) begin
      gnt_prev = '0;
    end else begin
      if (bus.gnt != '0 && bus.gnt != gnt_prev) begin
        if (exp_q.size() == 0) begin
          chk("sb_unexpected_gnt", bus.gnt, '0);
        end else begin
          exp_gnt = exp_q.pop_front();
          chk("sb_gnt_order", bus.gnt, exp_gnt);
        end
        gnt_start = cyc;
      end
      if (gnt_prev != '0 && bus.gnt != gnt_prev) last_len = cyc - gnt_start;
      gnt_prev = bus.gnt;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] tk, exp_tk;
    int at, bad, ovr_cnt;

    rst_n      = 1'b0;
    bus.enable = 1'b0;
    bus.req    = '0;
    bus.done   = '0;
    repeat (3) step();
    chk("rst_gnt", bus.gnt, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_tick", bus.period_tick, 0);
    chk("rst_overrun", bus.overrun, 0);
    chk("rst_timeout", bus.timeout_flag, 0);
    chk("rst_last_id", bus.last_id, 0);
    rst_n = 1'b1;
    step();

    // Ticks with no requesters
    bus.enable = 1'b1;
    cyc0 = cyc;
    tk = '0; bad = 0;
    for (int k = 1; k <= 59; k++) begin
      step();
      tk[k] = bus.period_tick;
      if (bus.gnt != '0 || bus.busy || bus.overrun) bad++;
    end
    exp_tk = '0;
    exp_tk[19] = 1'b1; exp_tk[39] = 1'b1; exp_tk[59] = 1'b1;
    chk("t1_tick_cycles", tk, exp_tk);
    chk("t1_quiet", bad, 0);

    // Two requesters, then all four from rotated pointer
    step();
    bus.req = 4'b0101;
    exp_q.push_back(4'b0001);
    exp_q.push_back(4'b0100);
    wait_gnt(40, at);
    chk("t2_first_gnt_cycle", at, 81);
    serve();
    chk("t2_gnt_released", bus.gnt, 0);
    wait_gnt(10, at);
    chk("t2_second_gnt_cycle", at, 85);
    chk("t2_first_len", last_len, 3);
    serve();
    chk("t2_busy_scan", bus.busy, 1);
    step();
    chk("t2_busy_done", bus.busy, 0);
    chk("t2_second_len", last_len, 3);
    chk("t2_last_id", bus.last_id, 2);

    bus.req = 4'b1111;
    exp_q.push_back(4'b1000);
    exp_q.push_back(4'b0001);
    exp_q.push_back(4'b0010);
    exp_q.push_back(4'b0100);
    for (int g = 0; g < 4; g++) begin
      wait_gnt(40, at);
      chk("t2_rr_gnt_cycle", at, 101 + 4 * g);
      serve();
    end

    // Client 1 never signals done
    bus.req = 4'b0010;
    exp_q.push_back(4'b0010);
    wait_gnt(40, at);
    chk("t3_gnt_cycle", at, 121);
    chk("t3_last_id", bus.last_id, 1);
`ifdef SCHED_TIMEOUT_EN
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (bus.gnt != 4'b0010 || bus.timeout_flag) bad++;
    end
    chk("t3_held_before_timeout", bad, 0);
    step();
    chk("t3_gnt_revoked", bus.gnt, 0);
    chk("t3_timeout_pulse", bus.timeout_flag, 1);
    step();
    chk("t3_timeout_single", bus.timeout_flag, 0);
    chk("t3_busy_after_scan", bus.busy, 0);
    chk("t3_gnt_len", last_len, 5);
`else
    bad = 0; ovr_cnt = 0;
    for (int i = 0; i < 45; i++) begin
      step();
      if (bus.gnt != 4'b0010 || !bus.busy || bus.overrun != bus.period_tick) bad++;
      if (bus.overrun) ovr_cnt++;
    end
    chk("t4_held_and_overrun_on_tick", bad, 0);
    chk("t4_overrun_count", ovr_cnt, 2);
    bus.req = '0;
    step();
    chk("t4_req_drop_release", bus.gnt, 0);
    step();
`endif

    // Disable mid-grant; then re-enable and check pointer retention
    bus.req = 4'b0001;
    exp_q.push_back(4'b0001);
    wait_gnt(45, at);
    step();
    bus.enable = 1'b0;
    step();
    chk("t5_gnt_off", bus.gnt, 0);
    chk("t5_busy_off", bus.busy, 0);
    chk("t5_cnt_zero", bus.dbg_cnt, 0);
    chk("t5_last_id_kept", bus.last_id, 0);
    bus.req = '0;
    repeat (3) step();
    bus.enable = 1'b1;
    cyc0 = cyc;
    at = -1;
    for (int i = 0; i < 40; i++) begin
      step();
      if (bus.period_tick) begin
        at = idx();
        break;
      end
    end
    chk("t5_first_tick_after_enable", at, 19);
    step();
    bus.req = 4'b0101;
    exp_q.push_back(4'b0100);
    exp_q.push_back(4'b0001);
    wait_gnt(40, at);
    chk("t5_ptr_kept_gnt_cycle", at, 41);
    serve();
    wait_gnt(10, at);
    serve();
    step();

    // Asynchronous reset mid-grant
    bus.req = 4'b0100;
    exp_q.push_back(4'b0100);
    wait_gnt(40, at);
    step();
    #200;
    rst_n = 1'b0;
    #1;
    bad = 0;
    if (bus.gnt != '0) bad++;
    if (bus.busy || bus.period_tick || bus.overrun || bus.timeout_flag) bad++;
    if (bus.last_id != '0) bad++;
    chk("t6_async_reset_outputs", bad, 0);
    chk("t6_state_idle", bus.dbg_state, 0);
    bus.req = 4'b1001;
    step();
    rst_n = 1'b1;
    cyc0 = cyc;
    exp_q.push_back(4'b0001);
    exp_q.push_back(4'b1000);
    wait_gnt(40, at);
    chk("t6_first_gnt_cycle", at, 21);
    serve();
    wait_gnt(10, at);
    serve();
    bus.req = '0;
    repeat (3) step();
    chk("sb_queue_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
